// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Instruction-fetch front end that drives the memory wrapper's instruction
// port (port 1). It owns the PC and keeps at most one read outstanding. Each
// returned word is queued together with its PC in a small FIFO, and decode
// drains that FIFO through a valid/ready handshake. A redirect never alters the
// address of a request that is still in flight. The old response is awaited
// in DROP and then thrown away.
//
// State table
//   state | meaning
//   IDLE  | no request outstanding (FIFO full, or just out of reset)
//   REQ   | request at pc outstanding; response is pushed into the FIFO
//   DROP  | stale request outstanding; response is discarded, then pc<=target
//
// Ports
//   CLK          in   clock, rising-edge
//   RST          in   asynchronous active-high reset
//   MEM_ADDR1    out  fetch address (the pc register)
//   MEM_READ1    out  fetch request, high in REQ and DROP
//   MEM_DOUT1    in   returned instruction word
//   MEM_VALID1   in   one-cycle response strobe
//   REDIRECT     in   one-cycle request for a new fetch stream
//   REDIRECT_PC  in   new stream address (low two bits ignored)
//   IF_VALID     out  FIFO head is valid
//   IF_INSTR     out  instruction at FIFO head
//   IF_PC        out  PC of FIFO head
//   IF_READY     in   decode accepts the head entry
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] MEM_ADDR1,
  output logic        MEM_READ1,
  input  logic [31:0] MEM_DOUT1,
  input  logic        MEM_VALID1,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  input  logic        IF_READY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   target, target_nxt;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;

  logic [31:0]   redirect_pc_al;
  logic          push, pop, room;

  assign redirect_pc_al = REDIRECT_PC & 32'hFFFF_FFFC;

  // A redirect squashes the head presented in the same cycle, so it blocks pop.
  assign pop  = IF_VALID && IF_READY && !REDIRECT;
  assign push = (state == S_REQ) && MEM_VALID1 && !REDIRECT;

  assign count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign room       = (count_next < DEPTH_C);

  assign MEM_ADDR1 = pc;
  assign MEM_READ1 = (state == S_REQ) || (state == S_DROP);

  assign IF_VALID = (count != '0);
  assign IF_INSTR = instr_q[rd_ptr];
  assign IF_PC    = pc_q[rd_ptr];

  // ---------------------------------------------------------------------------
  // Next-state / pc / target
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    target_nxt = target;
    case (state)
      S_IDLE: begin
        if (REDIRECT) begin
          pc_nxt    = redirect_pc_al;
          state_nxt = S_REQ;
        end else if (room) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (REDIRECT) begin
          if (MEM_VALID1) begin
            // Request already completed: the new stream can start right away.
            pc_nxt = redirect_pc_al;
          end else begin
            // Request still in flight: pc must not move until it returns.
            target_nxt = redirect_pc_al;
            state_nxt  = S_DROP;
          end
        end else if (MEM_VALID1) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = room ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (MEM_VALID1) begin
          pc_nxt    = REDIRECT ? redirect_pc_al : target;
          state_nxt = S_REQ;
        end else if (REDIRECT) begin
          target_nxt = redirect_pc_al;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      target <= 32'h0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      target <= target_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= 32'h0;
      end
    end else if (push) begin
      instr_q[wr_ptr] <= MEM_DOUT1;
      pc_q[wr_ptr]    <= pc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (REDIRECT) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

- Instruction-fetch front end that sits directly upstream of the memory wrapper's instruction port (port 1, served by the L1 instruction cache).
- Owns the PC and issues one outstanding read at a time on MEM_ADDR1/MEM_READ1, then captures MEM_DOUT1 when MEM_VALID1 pulses.
- Fetched words are buffered with their PCs in a small FIFO that feeds decode through a valid/ready handshake.
- Handles branch/jump redirects without ever changing the address of a cache request that is still in flight.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- MEM_ADDR1  out  32  fetch address; equals the internal PC register.
- MEM_READ1  out  1  fetch request; high in states REQ and DROP.
- MEM_DOUT1  in  32  instruction word; sampled only when MEM_VALID1=1.
- MEM_VALID1  in  1  one-cycle response strobe for the current request.
- REDIRECT  in  1  one-cycle pulse requesting a new fetch stream.
- REDIRECT_PC  in  32  target address; bits [1:0] are forced to 0 internally.
- IF_VALID  out  1  FIFO non-empty; head entry is presented.
- IF_INSTR  out  32  instruction at the FIFO head.
- IF_PC  out  32  PC of the FIFO head entry.
- IF_READY  in  1  decode accepts the head entry; a pop occurs when IF_VALID && IF_READY && !REDIRECT.

## Operation
- State machine: IDLE (MEM_READ1=0), REQ (MEM_READ1=1; response is kept), DROP (MEM_READ1=1; response is discarded). Registers: pc, target, FIFO, count.
- push = (state==REQ) && MEM_VALID1 && !REDIRECT. count_next = count + push − pop.
- MEM_ADDR1 holds constant for as long as MEM_READ1 is high and MEM_VALID1 has not arrived. The memory side relies on this during cache refills.
- IDLE:
  - REDIRECT: pc←REDIRECT_PC, flush FIFO, go to REQ.
  - Otherwise, if count_next < DEPTH, go to REQ.
- REQ:
  - MEM_VALID1 && !REDIRECT: push {pc, MEM_DOUT1}, pc←pc+4. Stay in REQ if count_next < DEPTH, else go to IDLE.
  - REDIRECT && MEM_VALID1: discard the response, pc←REDIRECT_PC, flush, stay in REQ.
  - REDIRECT && !MEM_VALID1: target←REDIRECT_PC, flush, go to DROP. pc is unchanged.
- DROP:
  - MEM_VALID1: discard the response. pc←target, or REDIRECT_PC if REDIRECT is also high. Go to REQ.
  - REDIRECT && !MEM_VALID1: target←REDIRECT_PC (the latest redirect wins), flush, stay in DROP.
- Flush sets count, read pointer and write pointer to 0.
- A redirect takes priority over a pop in the same cycle. The stage issuing REDIRECT squashes the head presented that cycle.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- IF_* outputs are combinational from the FIFO head. IF_INSTR/IF_PC are don't-care when IF_VALID=0.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, target=0, count=0.
  - MEM_READ1=0, MEM_ADDR1=RESET_PC.
  - IF_VALID=0, IF_INSTR=0, IF_PC=0.
- MEM_READ1 rises in the first cycle after RST deasserts.
- Responses:
  - A response may arrive in the same cycle MEM_READ1 is first high (L1 hit) or any number of cycles later (miss).
  - Sustained hits give one push per cycle.
- Push-to-IF_VALID latency: the entry is visible in the cycle after the push.
- Redirect effects:
  - The flush is visible the cycle after REDIRECT: IF_VALID=0.
  - The first new-stream request is on MEM_ADDR1 the cycle after REDIRECT when in IDLE/REQ+VALID, or the cycle after the old response when in DROP.
- Full FIFO: no request is issued while count_next = DEPTH. The FIFO never overflows.
- RST mid-request: everything returns to reset values immediately. MEM_READ1 drops asynchronously.

## Test plan
- Hits, zero-cycle valid, IF_READY=1, RESET_PC=0x100 -> MEM_ADDR1 sequence 0x100, 0x104, 0x108 on consecutive cycles. IF_PC/IF_INSTR follow one cycle later. No bubbles.
- Miss: MEM_VALID1 held low for 6 cycles -> MEM_ADDR1 stays 0x100 and MEM_READ1 stays high for all 6 cycles. The word is pushed on the 7th cycle.
- IF_READY=0, DEPTH=4 -> exactly 4 pushes, then MEM_READ1=0. One pop -> MEM_READ1 is high again the next cycle at the 5th address.
- REDIRECT to 0x2000 during a miss at 0x108 -> MEM_ADDR1 holds 0x108 until valid. That word is discarded, IF_VALID=0, and the next request is 0x2000. A second redirect to 0x3000 while in DROP -> the next request is 0x3000.
- REDIRECT to 0x40 coincident with MEM_VALID1 and a pop -> the response is dropped, no pop occurs, the FIFO is empty the next cycle, and the next request is 0x40.
- Wrap-around and reset: REDIRECT to 0xFFFF_FFFC -> the next address is 0x0. Asserting RST mid-miss -> MEM_READ1=0 immediately, and after release the first request is RESET_PC.
